alu_arbiter: RTL

Round-robin arbiter sharing the single combinational 32-bit `alu` between `NREQ` independent requesters, for example the main datapath, the branch-compare path and the address-generation path. It accepts one operation per cycle over a valid/ready handshake and drives the shared `alu`. It returns the registered result, tagged with the requester ID, through a one-entry output slot with backpressure.

---
 rtl/alu_defs.sv | 20 ++
 rtl/alu_arbiter_alu.sv | 27 ++
 rtl/alu_arbiter.sv | 106 ++++++++++
 3 files changed

// File: rtl/alu_defs.sv
// Shared ALU op-code constants, legality decode and result-slot state type
// used by the arbiter and its ALU.
package alu_defs;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   typedef enum logic {
      SLOT_EMPTY,
      SLOT_FULL
   } slot_state_e;

   function automatic logic alu_op_legal(input logic [2:0] op);
      return op inside {ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT};
   endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational 32-bit ALU; illegal op codes produce zero.
module alu
   import alu_defs::*;
(
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic [2:0]  op_i,
   output logic [31:0] y_o
);

   logic [31:0] diff;

   always_comb begin
      diff = a_i - b_i;
      y_o  = '0;
      case (op_i)
         ALU_AND: y_o = a_i & b_i;
         ALU_OR:  y_o = a_i | b_i;
         ALU_ADD: y_o = a_i + b_i;
         ALU_SUB: y_o = diff;
         // Native SLT: sign of the wrapped difference, overflow not corrected.
         ALU_SLT: y_o = {31'b0, diff[31]};
         default: y_o = '0;
      endcase
   end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between NREQ requesters, returning
// tagged results through a one-entry output slot with backpressure.
module alu_arbiter
   import alu_defs::*;
#(
   parameter int unsigned NREQ = 2,
   parameter int unsigned IDW  = 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [32*NREQ-1:0]   req_a,
   input  logic [32*NREQ-1:0]   req_b,
   input  logic [3*NREQ-1:0]    req_op,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [31:0]          rsp_data,
   output logic [IDW-1:0]       rsp_id,
   output logic                 rsp_err
);

   localparam int unsigned SELW = $clog2(NREQ);

   slot_state_e    state_q;
   logic [IDW-1:0] last_q;
   logic [31:0]    data_q;
   logic [IDW-1:0] id_q;
   logic           err_q;

   logic           can_accept;
   logic           found;
   logic           accept;
   logic [IDW-1:0] gnt_d;
   logic [31:0]    alu_a;
   logic [31:0]    alu_b;
   logic [2:0]     alu_op;
   logic [31:0]    alu_y;

   assign can_accept = (state_q == SLOT_EMPTY) || rsp_ready;
   assign accept     = can_accept && found;

   // Rotating search as two passes: indices above last first, then wrap from 0.
   always_comb begin
      found = 1'b0;
      gnt_d = '0;
      for (int unsigned j = 0; j < NREQ; j++) begin
         if (!found && req_valid[j[SELW-1:0]] && (j > 32'(last_q))) begin
            found = 1'b1;
            gnt_d = IDW'(j);
         end
      end
      for (int unsigned j = 0; j < NREQ; j++) begin
         if (!found && req_valid[j[SELW-1:0]] && (j <= 32'(last_q))) begin
            found = 1'b1;
            gnt_d = IDW'(j);
         end
      end
   end

   always_comb begin
      req_ready = '0;
      alu_a     = '0;
      alu_b     = '0;
      alu_op    = ALU_AND;
      for (int unsigned j = 0; j < NREQ; j++) begin
         if (accept && (gnt_d == IDW'(j))) begin
            req_ready[j[SELW-1:0]] = 1'b1;
            alu_a  = req_a[32*j +: 32];
            alu_b  = req_b[32*j +: 32];
            alu_op = req_op[3*j +: 3];
         end
      end
   end

   alu u_alu (
      .a_i  (alu_a),
      .b_i  (alu_b),
      .op_i (alu_op),
      .y_o  (alu_y)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= SLOT_EMPTY;
         data_q  <= '0;
         id_q    <= '0;
         err_q   <= 1'b0;
         last_q  <= IDW'(NREQ - 1);
      end else if (accept) begin
         state_q <= SLOT_FULL;
         data_q  <= alu_y;
         id_q    <= gnt_d;
         err_q   <= !alu_op_legal(alu_op);
         last_q  <= gnt_d;
      end else if (rsp_ready) begin
         state_q <= SLOT_EMPTY;
      end
   end

   assign rsp_valid = (state_q == SLOT_FULL);
   assign rsp_data  = data_q;
   assign rsp_id    = id_q;
   assign rsp_err   = err_q;

endmodule
